vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Time-slot arbiter that shares a single-port, synchronous-read frame buffer between the VGA scan-out path and a pixel-writing requester. It also sequences the VGA datapath: it generates the per-pixel tick that advances the timing generator. Each pixel period is divided into SLOTS clock cycles. Slot 0 is reserved for the display read while the display is visible; every other cycle goes to buffered writes.

## Interface
Parameters:
- AW, 15, frame-buffer address width.
- DW, 3, pixel width ({R,G,B}, 1 bit each).
- SLOTS, 4, clock cycles per pixel; legal range 2..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- pix_tick  out  1  high during every slot-0 cycle; advances the VGA timing generator.
- disp_en  in  1  1 = visible area; sampled only in slot 0.
- disp_addr  in  AW  pixel address to fetch; sampled only in slot 0.
- disp_data  out  DW  last fetched pixel, registered.
- disp_valid  out  1  one-cycle pulse when disp_data updates.
- wr_valid  in  1  write request.
- wr_ready  out  1  write buffer can accept.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write pixel.
- mem_addr  out  AW  frame-buffer address.
- mem_we  out  1  frame-buffer write enable.
- mem_wdata  out  DW  frame-buffer write data.
- mem_rdata  in  DW  read data; valid the cycle after the address is presented.

## Operation
- Slot counter:
  - Runs 0..SLOTS-1, free-running, and wraps to 0.
  - It is 0 in the first cycle after reset release.
- Reset values while rst=0:
  - slot=0.
  - pix_tick=0, disp_valid=0, disp_data=0.
  - wr_ready=0, FIFO empty.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- pix_tick is a decode of slot==0, gated off while in reset.
- Read slot (slot==0 and disp_en==1):
  - mem_addr=disp_addr, mem_we=0.
  - In slot 1, mem_rdata is captured into disp_data on the rising edge that ends slot 1.
  - disp_valid is high during slot 2 only.
- Slot 0 with disp_en==0:
  - The slot is treated as a writer slot.
  - No read is issued, disp_valid stays 0 for that pixel, and disp_data holds its value.
- Write buffer: 2-entry FIFO, in order.
  - wr_ready = (count < 2) when out of reset; it does not depend on a same-cycle pop.
  - Push when wr_valid && wr_ready.
- Writer slot with a non-empty FIFO:
  - mem_we=1, mem_addr/mem_wdata taken from the FIFO head; pop at the clock edge.
  - An entry pushed in cycle t is never written before cycle t+1.
- Writer slot with an empty FIFO: mem_we=0 and mem_addr holds its previous value.
- Push and pop in the same cycle are allowed; count is unchanged.
- mem_addr, mem_we and mem_wdata are combinational from slot, disp_en and the FIFO head.
- No hazard checking between reads and writes to the same address: the order is purely the slot order.
- Reset mid-operation:
  - FIFO contents are discarded.
  - An in-flight read is discarded: no disp_valid pulse after release.
  - The slot counter restarts at 0.

## Timing
- Display read latency: address in slot 0, disp_valid/disp_data in slot 2 (2 cycles).
- Write throughput:
  - SLOTS-1 writes per pixel period while visible.
  - SLOTS writes per period during blanking (disp_en==0).
- Write latency from push to mem_we:
  - 1 cycle when the next cycle is a writer slot and the FIFO was empty.
  - Worst case with SLOTS=4 and disp_en=1: push in slot 3, write in slot 1 = 2 cycles.
- Sustained wr_valid=1 while visible: wr_ready deasserts once the FIFO is full, and backpressure occurs only across read slots.
- All registers update on the rising edge of clk; rst clears them immediately, independent of clk.

## Test plan
- Reset: hold rst=0 for 10 cycles with wr_valid=1.
  - All outputs 0 and wr_ready=0 during reset.
  - After release, pix_tick is high in cycles 0, 4, 8, … (SLOTS=4).
- Display fetch: memory model holds addr 5 = 3'b101; disp_addr=5, disp_en=1.
  - Slot 0 shows mem_addr=5, mem_we=0.
  - disp_valid=1 only in slot 2, with disp_data=3'b101, held until the next fetch.
- Write stream while visible: 8 writes, addr 0..7, data (addr mod 8), wr_valid held high.
  - mem_we is never 1 in slot 0.
  - All 8 writes appear in order.
  - wr_ready drops to 0 when count=2.
  - Memory model contents match.
- Blanking: disp_en=0 with 8 queued writes.
  - mem_we is asserted in every slot including slot 0.
  - disp_valid stays 0; disp_data keeps its prior value 3'b101.
- Full FIFO and simultaneous events: FIFO full and a writer slot popping with wr_valid=1.
  - wr_ready=0 in that cycle, so no push.
  - The next cycle has count=1 and wr_ready=1.
  - A push plus a pop in the same cycle keeps count unchanged.
- Reset mid-operation: 2 entries queued and a read in flight; pulse rst=0 for 1 cycle.
  - After release, no mem_we until a new push.
  - No disp_valid for the aborted read.
  - pix_tick restarts in cycle 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port, synchronous-read frame buffer between the VGA
// scan-out path and a pixel-writing requester. Time is cut into pixel periods
// of SLOTS clock cycles. Slot 0 carries the display fetch while the display
// is visible. Every other cycle, and slot 0 during blanking, drains a 2-entry
// write FIFO into the frame buffer. The slot counter also produces pix_tick,
// which advances the VGA timing generator once per pixel.
//
// Handshake: wr_valid/wr_ready follow strict valid/ready semantics. A write
// transfers on a rising edge where both are high. wr_valid must not depend on
// wr_ready. wr_ready depends only on the registered FIFO count, so it never
// reflects a pop in the same cycle.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   pix_tick    high in every slot-0 cycle (low while in reset)
//   disp_en     visible area flag, used only in slot 0
//   disp_addr   pixel address to fetch, used only in slot 0
//   disp_data   last fetched pixel (registered)
//   disp_valid  one-cycle pulse in slot 2 when disp_data updates
//   wr_valid    write request
//   wr_ready    FIFO can accept a write
//   wr_addr     write address
//   wr_data     write pixel
//   mem_addr    frame-buffer address (combinational)
//   mem_we      frame-buffer write enable (combinational)
//   mem_wdata   frame-buffer write data (combinational)
//   mem_rdata   frame-buffer read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int SLOTS = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_tick,
  input  logic          disp_en,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = (SLOTS > 2) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  // ---------------------------------------------------------------------
  // Slot counter: free running 0..SLOTS-1.
  // ---------------------------------------------------------------------
  logic [SW-1:0] slot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else if (slot_q == LAST_SLOT) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  logic slot_zero;
  logic rd_slot;
  logic wr_slot;

  assign slot_zero = (slot_q == '0);
  // Slot 0 is a read slot only while visible; during blanking it writes.
  assign rd_slot   = slot_zero && disp_en;
  assign wr_slot   = !rd_slot;

  // Without the rst gate pix_tick would sit high through reset, since the
  // counter is held at 0.
  assign pix_tick  = rst && slot_zero;

  // ---------------------------------------------------------------------
  // Write FIFO: two entries, head/tail pointers plus an occupancy count.
  // ---------------------------------------------------------------------
  logic [AW-1:0] fifo_addr [2];
  logic [DW-1:0] fifo_data [2];
  logic          head_q;
  logic          tail_q;
  logic [1:0]    count_q;
  logic          push;
  logic          pop;

  assign wr_ready = rst && (count_q < 2'd2);
  assign push     = wr_valid && wr_ready;
  // The count holds only entries pushed on earlier edges, so an entry never
  // reaches the frame buffer in the cycle it is pushed.
  assign pop      = rst && wr_slot && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_addr[0] <= '0;
      fifo_addr[1] <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      tail_q       <= 1'b0;
    end else if (push) begin
      fifo_addr[tail_q] <= wr_addr;
      fifo_data[tail_q] <= wr_data;
      tail_q            <= ~tail_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= 1'b0;
    end else if (pop) begin
      head_q <= ~head_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame-buffer port mux. An idle writer slot keeps the address of the
  // previous cycle, so the address bus only toggles on real accesses.
  // ---------------------------------------------------------------------
  logic [AW-1:0] hold_addr_q;

  always_comb begin
    mem_addr  = hold_addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      mem_addr = '0;
    end else if (rd_slot) begin
      mem_addr = disp_addr;
    end else if (pop) begin
      mem_we    = 1'b1;
      mem_addr  = fifo_addr[head_q];
      mem_wdata = fifo_data[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_addr_q <= '0;
    end else begin
      hold_addr_q <= mem_addr;
    end
  end

  // ---------------------------------------------------------------------
  // Display read pipeline: address in slot 0, data returns in slot 1 and is
  // registered on the edge ending slot 1, giving a disp_valid pulse in
  // slot 2. Reset drops rd_pend_q, so an aborted fetch never pulses.
  // ---------------------------------------------------------------------
  logic          rd_pend_q;
  logic          disp_valid_q;
  logic [DW-1:0] disp_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_pend_q    <= rd_slot;
      disp_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        disp_data_q <= mem_rdata;
      end
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int AW = 15;
  localparam int DW = 3;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic          pix_tick;
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vga_fb_arbiter #(.AW(AW), .DW(DW), .SLOTS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_tick   (pix_tick),
    .disp_en    (disp_en),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // ---------------------------------------------------------------------
  // Frame-buffer model: synchronous read, address 5 preloaded with 3'b101.
  // ---------------------------------------------------------------------
  bit [DW-1:0] fb     [32768];
  bit          fb_set [32768];

  function automatic logic [DW-1:0] fb_read(input logic [AW-1:0] a);
    if (fb_set[a]) return fb[a];
    return (a == 15'd5) ? 3'b101 : 3'b000;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= fb_read(mem_addr);
    if (mem_we) begin
      fb[mem_addr]     <= mem_wdata;
      fb_set[mem_addr] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  int slot_m = 0;

  // Advance one clock; inputs are driven and outputs sampled after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    slot_m = (slot_m + 1) % 4;
  endtask

  task automatic align(input int s);
    for (int i = 0; i < 8 && slot_m != s; i++) step();
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [AW+DW+DW+3:0] obs;
    rst = 1'b0; wr_valid = 1'b1; wr_addr = 15'd3; wr_data = 3'd3;
    disp_en = 1'b1; disp_addr = 15'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      #2;
      obs = {pix_tick, disp_valid, disp_data, wr_ready, mem_we, mem_addr, mem_wdata};
      n_cmp++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got %h want 0", i, obs);
      end
    end
    wr_valid = 1'b0; disp_en = 1'b0;
    rst = 1'b1; slot_m = 0;
    for (int k = 0; k < 12; k++) begin
      #2;
      n_cmp++;
      if (pix_tick !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL reset_pix_tick cyc%0d: got %b want %b", k, pix_tick, (k % 4 == 0));
      end
      if (k == 0) begin
        n_cmp++;
        if (wr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_wr_ready_release: got %b want 1", wr_ready);
        end
      end
      step();
    end
  endtask

  task automatic test_display();
    disp_en = 1'b1; disp_addr = 15'd5;
    #2;
    n_cmp++;
    if (mem_addr !== 15'd5 || mem_we !== 1'b0 || disp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_slot0: got addr=%0d we=%b dv=%b want addr=5 we=0 dv=0", mem_addr, mem_we, disp_valid);
    end
    step(); #2;
    n_cmp++;
    if (disp_valid !== 1'b0 || disp_data !== 3'b000) begin
      n_fail++;
      $display("FAIL disp_slot1: got dv=%b data=%b want dv=0 data=000", disp_valid, disp_data);
    end
    step(); #2;
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_data !== 3'b101) begin
      n_fail++;
      $display("FAIL disp_slot2: got dv=%b data=%b want dv=1 data=101", disp_valid, disp_data);
    end
    step(); #2;
    n_cmp++;
    if (disp_valid !== 1'b0 || disp_data !== 3'b101) begin
      n_fail++;
      $display("FAIL disp_slot3: got dv=%b data=%b want dv=0 data=101", disp_valid, disp_data);
    end
    step();
  endtask

  // Streams 8 writes with wr_valid held high; expected FIFO behaviour comes
  // from the scoreboard queue whose size is the expected occupancy.
  task automatic test_write_stream(input logic visible, input int base);
    logic [AW+DW-1:0] exp_q[$];
    logic exp_pop, exp_ready, saw_full, saw_slot0_we;
    int idx, cyc, n_we;
    idx = 0; cyc = 0; n_we = 0; saw_full = 1'b0; saw_slot0_we = 1'b0;
    disp_en = visible; disp_addr = 15'd5;
    while ((idx < 8 || exp_q.size() > 0) && cyc < 100) begin
      wr_valid = (idx < 8);
      wr_addr  = 15'(base + idx);
      wr_data  = 3'(idx);
      #2;
      exp_ready = (exp_q.size() < 2);
      exp_pop   = (exp_q.size() > 0) && (!visible || slot_m != 0);
      n_cmp++;
      if (wr_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL stream_wr_ready cyc%0d: got %b want %b", cyc, wr_ready, exp_ready);
      end
      n_cmp++;
      if (mem_we !== exp_pop) begin
        n_fail++;
        $display("FAIL stream_mem_we cyc%0d slot%0d: got %b want %b", cyc, slot_m, mem_we, exp_pop);
      end
      if (visible && slot_m == 0) begin
        n_cmp++;
        if (mem_addr !== 15'd5) begin
          n_fail++;
          $display("FAIL stream_read_addr cyc%0d: got %0d want 5", cyc, mem_addr);
        end
      end
      if (!visible) begin
        n_cmp++;
        if (disp_valid !== 1'b0 || disp_data !== 3'b101) begin
          n_fail++;
          $display("FAIL blank_disp cyc%0d: got dv=%b data=%b want dv=0 data=101", cyc, disp_valid, disp_data);
        end
      end
      if (exp_pop) begin
        n_cmp++;
        if ({mem_addr, mem_wdata} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stream_order cyc%0d: got addr=%0d data=%0d want addr=%0d data=%0d",
                   cyc, mem_addr, mem_wdata, exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
        end
        void'(exp_q.pop_front());
      end
      if (mem_we) n_we++;
      if (mem_we && slot_m == 0) saw_slot0_we = 1'b1;
      if (!exp_ready) saw_full = 1'b1;
      if (wr_valid && exp_ready) begin
        exp_q.push_back({wr_addr, wr_data});
        idx++;
      end
      step();
      cyc++;
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (cyc >= 100) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d cycles want < 100", cyc);
    end
    n_cmp++;
    if (visible ? !saw_full : !saw_slot0_we) begin
      n_fail++;
      $display("FAIL stream_%s: got 0 want 1", visible ? "ready_drop" : "slot0_write");
    end
    n_cmp++;
    if (n_we !== 8) begin
      n_fail++;
      $display("FAIL stream_write_count: got %0d want 8", n_we);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (fb[base + i] !== 3'(i) || fb_set[base + i] !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_mem_content addr%0d: got %0d want %0d", base + i, fb[base + i], i);
      end
    end
  endtask

  task automatic test_full_fifo();
    wr_valid = 1'b0; disp_en = 1'b1; disp_addr = 15'd5;
    align(3);
    wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 3'd1;
    #2;
    n_cmp++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL full_s3: got rdy=%b we=%b want rdy=1 we=0", wr_ready, mem_we);
    end
    step();
    wr_addr = 15'd101; wr_data = 3'd2;
    #2;
    n_cmp++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd5) begin
      n_fail++;
      $display("FAIL full_s0: got rdy=%b we=%b addr=%0d want rdy=1 we=0 addr=5", wr_ready, mem_we, mem_addr);
    end
    step();
    wr_addr = 15'd102; wr_data = 3'd3;
    #2;
    n_cmp++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'd100 || mem_wdata !== 3'd1) begin
      n_fail++;
      $display("FAIL full_pop_no_push: got rdy=%b we=%b addr=%0d data=%0d want rdy=0 we=1 addr=100 data=1",
               wr_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    #2;
    n_cmp++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd101 || mem_wdata !== 3'd2) begin
      n_fail++;
      $display("FAIL full_push_pop: got rdy=%b we=%b addr=%0d data=%0d want rdy=1 we=1 addr=101 data=2",
               wr_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    wr_valid = 1'b0;
    #2;
    n_cmp++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd102 || mem_wdata !== 3'd3) begin
      n_fail++;
      $display("FAIL full_count_kept: got rdy=%b we=%b addr=%0d data=%0d want rdy=1 we=1 addr=102 data=3",
               wr_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    #2;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== 15'd5) begin
      n_fail++;
      $display("FAIL full_read_slot: got we=%b addr=%0d want we=0 addr=5", mem_we, mem_addr);
    end
    step();
    #2;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== 15'd5) begin
      n_fail++;
      $display("FAIL empty_hold_addr: got we=%b addr=%0d want we=0 addr=5", mem_we, mem_addr);
    end
    step();
  endtask

  task automatic test_reset_mid();
    wr_valid = 1'b0; disp_en = 1'b1; disp_addr = 15'd5;
    align(3);
    wr_valid = 1'b1; wr_addr = 15'd200; wr_data = 3'd4;
    step();
    wr_addr = 15'd201; wr_data = 3'd5;
    #2;
    n_cmp++;
    if (mem_addr !== 15'd5 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_issue: got addr=%0d we=%b want addr=5 we=0", mem_addr, mem_we);
    end
    step();
    wr_valid = 1'b0; disp_en = 1'b0; rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== 15'd0 || wr_ready !== 1'b0 || pix_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got we=%b addr=%0d rdy=%b tick=%b want 0 0 0 0",
               mem_we, mem_addr, wr_ready, pix_tick);
    end
    step();
    rst = 1'b1; slot_m = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      n_cmp++;
      if (pix_tick !== (k % 4 == 0) || mem_we !== 1'b0 || disp_valid !== 1'b0 || wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_after_release cyc%0d: got tick=%b we=%b dv=%b rdy=%b want tick=%b we=0 dv=0 rdy=1",
                 k, pix_tick, mem_we, disp_valid, wr_ready, (k % 4 == 0));
      end
      step();
    end
    wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 3'd6;
    #2;
    n_cmp++;
    if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_new_push: got we=%b rdy=%b want we=0 rdy=1", mem_we, wr_ready);
    end
    step();
    wr_valid = 1'b0;
    #2;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd300 || mem_wdata !== 3'd6) begin
      n_fail++;
      $display("FAIL mid_new_write: got we=%b addr=%0d data=%0d want we=1 addr=300 data=6",
               mem_we, mem_addr, mem_wdata);
    end
    step();
  endtask

  initial begin
    rst = 1'b0; disp_en = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_display();
    test_write_stream(1'b1, 0);
    align(3);
    test_write_stream(1'b0, 8);
    test_full_fifo();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
